ddr_access_buff_param: RTL and testbench

Parametrised DDR3 access buffer, sitting between the local frame RAM and the DDR3 controller user port.
- Write path: fetches a programmed number of beats from RAM through a configurable-latency pipeline into an internal FIFO, which the controller drains with i_ddr3_wr_data_rdy.
- Read path: retimes controller read data into RAM write beats through a configurable register pipeline.
- Flow control uses an exact credit counter rather than an almost-full flag, so no beat is lost or over-fetched.

---
 rtl/ddr_access_buff_param.sv | 204 ++++++++++++++++++++
 tb/tb_ddr_access_buff_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_access_buff_param.sv
// rtl/ddr_access_buff_param.sv - DDR3 access buffer between frame RAM and DDR3 controller user port
//
// Write path: after a write command is accepted, fetches i_burst_len beats from RAM.
// A credit counter caps issued-but-unpopped beats at DEPTH, so the FIFO cannot overflow.
// Read path: retimes controller read beats to RAM write beats through RD_PIPE stages.
// Optional build macro: DDR_BUFF_UFLOW_DET_EN enables the sticky o_wr_underflow detector.
//
// Ports:
//   i_ddr3_sclk, i_rst_n             clock, async active-low reset
//   i_ddr3_wr_rdn, i_ddr3_ack        command type (registered once) and controller accept
//   i_burst_len                      beats to fetch, sampled with the accepting ack
//   i_ddr3_wr_data_rdy               controller pops one write beat
//   i_ddr3_op_done                   command complete, returns to IDLE
//   i_ram_rd_data, o_ram_rd_en       RAM fetch interface (data RAM_LAT cycles after strobe)
//   o_ddr3_wr_data                   popped write beat, registered
//   i_ddr3_rd_data_vld/_data         controller read beats
//   o_ram_wr_data_vld/_data          read beats delayed RD_PIPE cycles
//   o_busy, o_wr_underflow           FSM not idle, sticky underflow flag
module ddr_access_buff_param #(
    parameter int DW      = 128,
    parameter int DEPTH   = 16,
    parameter int RAM_LAT = 3,
    parameter int RD_PIPE = 1,
    parameter int BLW     = 10
) (
    input  logic           i_ddr3_sclk,
    input  logic           i_rst_n,
    input  logic           i_ddr3_wr_rdn,
    input  logic           i_ddr3_ack,
    input  logic [BLW-1:0] i_burst_len,
    input  logic           i_ddr3_wr_data_rdy,
    input  logic           i_ddr3_op_done,
    input  logic [DW-1:0]  i_ram_rd_data,
    input  logic           i_ddr3_rd_data_vld,
    input  logic [DW-1:0]  i_ddr3_rd_data,
    output logic           o_ram_rd_en,
    output logic [DW-1:0]  o_ddr3_wr_data,
    output logic           o_ram_wr_data_vld,
    output logic [DW-1:0]  o_ram_wr_data,
    output logic           o_busy,
    output logic           o_wr_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 r_wr_rdn_q;
    logic [BLW-1:0]       burst_q, burst_d;
    logic [BLW-1:0]       issued_q, issued_d;
    logic [AW:0]          credit_q, credit_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 ram_rd_en_q, ram_rd_en_d;
    logic [RAM_LAT-1:0]   lat_vld_q, lat_vld_d;
    logic [DW-1:0]        wr_data_q, wr_data_d;
    logic [DW-1:0]        mem_q [DEPTH];

    logic                 start, stop, push, pop, fifo_empty;

    logic [RD_PIPE-1:0]   rd_vld_q, rd_vld_d;
    logic [DW-1:0]        rd_data_q [RD_PIPE];

    always_comb begin
        start      = (state_q == ST_IDLE) && i_ddr3_ack && r_wr_rdn_q;
        stop       = (state_q == ST_FETCH) && i_ddr3_op_done;
        fifo_empty = (cnt_q == '0);
        // op_done wins: no push or pop lands in the cycle that returns to IDLE
        push       = lat_vld_q[RAM_LAT-1] && (state_q == ST_FETCH) && !i_ddr3_op_done;
        pop        = i_ddr3_wr_data_rdy && !fifo_empty && (state_q == ST_FETCH) && !i_ddr3_op_done;

        state_d   = state_q;
        burst_d   = burst_q;
        issued_d  = issued_q + BLW'(ram_rd_en_q);
        credit_d  = credit_q + (AW+1)'(ram_rd_en_q) - (AW+1)'(pop);
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_data_d = pop ? mem_q[rd_ptr_q] : wr_data_q;
        // shift the fetch strobe; the top bit marks RAM data valid this cycle
        lat_vld_d = RAM_LAT'({lat_vld_q, ram_rd_en_q});

        if (state_q == ST_IDLE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end

        if (start) begin
            state_d  = ST_FETCH;
            burst_d  = i_burst_len;
            issued_d = '0;
            credit_d = '0;
        end

        if (stop) begin
            state_d   = ST_IDLE;
            credit_d  = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            lat_vld_d = '0;
        end

        // credit_d < DEPTH leaves room for the beat this strobe will bring
        ram_rd_en_d = (state_d == ST_FETCH) && (credit_d < DEPTH_C) && (issued_d < burst_d);
    end

    always_ff @(posedge i_ddr3_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            r_wr_rdn_q  <= 1'b0;
            burst_q     <= '0;
            issued_q    <= '0;
            credit_q    <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_rd_en_q <= 1'b0;
            lat_vld_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            r_wr_rdn_q  <= i_ddr3_wr_rdn;
            burst_q     <= burst_d;
            issued_q    <= issued_d;
            credit_q    <= credit_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_rd_en_q <= ram_rd_en_d;
            lat_vld_q   <= lat_vld_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // FIFO storage is not reset; occupancy alone defines validity
    always_ff @(posedge i_ddr3_sclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_ram_rd_data;
        end
    end

    assign o_ram_rd_en    = ram_rd_en_q;
    assign o_ddr3_wr_data = wr_data_q;
    assign o_busy         = (state_q == ST_FETCH);

`ifdef DDR_BUFF_UFLOW_DET_EN
    logic uflow_q, uflow_d;

    always_comb begin
        uflow_d = uflow_q;
        if (start) begin
            uflow_d = 1'b0;
        end else if (i_ddr3_wr_data_rdy && (state_q == ST_FETCH) && fifo_empty &&
                     !((credit_q == '0) && (issued_q == burst_q))) begin
            // rdy while data is still owed by the fetch pipeline
            uflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_ddr3_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            uflow_q <= 1'b0;
        end else begin
            uflow_q <= uflow_d;
        end
    end

    assign o_wr_underflow = uflow_q;
`else
    assign o_wr_underflow = 1'b0;
`endif

    // read path: independent of the FSM
    always_comb begin
        rd_vld_d = RD_PIPE'({rd_vld_q, i_ddr3_rd_data_vld});
    end

    always_ff @(posedge i_ddr3_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_vld_q <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
        end
    end

    always_ff @(posedge i_ddr3_sclk) begin
        rd_data_q[0] <= i_ddr3_rd_data;
        for (int i = 1; i < RD_PIPE; i++) begin
            rd_data_q[i] <= rd_data_q[i-1];
        end
    end

    assign o_ram_wr_data_vld = rd_vld_q[RD_PIPE-1];
    assign o_ram_wr_data     = rd_data_q[RD_PIPE-1];

endmodule

// File: tb/tb_ddr_access_buff_param.sv
// tb/tb_ddr_access_buff_param.sv - directed self-checking bench for ddr_access_buff_param
module tb_ddr_access_buff_param;

`ifdef DDR_BUFF_UFLOW_DET_EN
    localparam logic EXP_UF = 1'b1;
`else
    localparam logic EXP_UF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_rdn = 1'b1;
    logic         ack = 1'b0;
    logic [9:0]   burst = '0;
    logic         rdy = 1'b0;
    logic         op_done = 1'b0;
    logic [127:0] ram_data1 = '0;
    logic [127:0] ram_data2 = '0;
    logic         rd_vld = 1'b0;
    logic [127:0] rd_data = '0;

    logic         d1_rd_en, d1_wvld, d1_busy, d1_uf;
    logic [127:0] d1_wr_data, d1_wdat;
    logic         d2_rd_en, d2_wvld, d2_busy, d2_uf;
    logic [127:0] d2_wr_data, d2_wdat;

    int checks = 0;
    int errors = 0;

    logic [127:0] sr1 [3];
    logic [127:0] sr2 [8];
    logic [127:0] addr1 = '0;
    logic [127:0] addr2 = '0;
    logic [127:0] last_wr = '0;
    logic [127:0] exp_next = '0;
    logic         mon = 1'b0;
    int           rd_en_cnt = 0;
    int           beats = 0;
    int           first = -1;

    always #5 clk = ~clk;

    ddr_access_buff_param #(.DW(128), .DEPTH(16), .RAM_LAT(3), .RD_PIPE(1), .BLW(10)) dut (
        .i_ddr3_sclk(clk), .i_rst_n(rst_n), .i_ddr3_wr_rdn(wr_rdn), .i_ddr3_ack(ack),
        .i_burst_len(burst), .i_ddr3_wr_data_rdy(rdy), .i_ddr3_op_done(op_done),
        .i_ram_rd_data(ram_data1), .i_ddr3_rd_data_vld(rd_vld), .i_ddr3_rd_data(rd_data),
        .o_ram_rd_en(d1_rd_en), .o_ddr3_wr_data(d1_wr_data), .o_ram_wr_data_vld(d1_wvld),
        .o_ram_wr_data(d1_wdat), .o_busy(d1_busy), .o_wr_underflow(d1_uf));

    ddr_access_buff_param #(.DW(128), .DEPTH(16), .RAM_LAT(8), .RD_PIPE(4), .BLW(10)) dut2 (
        .i_ddr3_sclk(clk), .i_rst_n(rst_n), .i_ddr3_wr_rdn(wr_rdn), .i_ddr3_ack(ack),
        .i_burst_len(burst), .i_ddr3_wr_data_rdy(rdy), .i_ddr3_op_done(op_done),
        .i_ram_rd_data(ram_data2), .i_ddr3_rd_data_vld(rd_vld), .i_ddr3_rd_data(rd_data),
        .o_ram_rd_en(d2_rd_en), .o_ddr3_wr_data(d2_wr_data), .o_ram_wr_data_vld(d2_wvld),
        .o_ram_wr_data(d2_wdat), .o_busy(d2_busy), .o_wr_underflow(d2_uf));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock; RAM models return the addressed word RAM_LAT cycles after each strobe
    task automatic tick();
        logic en1, en2;
        en1 = d1_rd_en;
        en2 = d2_rd_en;
        @(posedge clk);
        #1;
        for (int i = 2; i > 0; i--) sr1[i] = sr1[i-1];
        sr1[0] = en1 ? addr1 : '0;
        if (en1) addr1 = addr1 + 1;
        for (int i = 7; i > 0; i--) sr2[i] = sr2[i-1];
        sr2[0] = en2 ? addr2 : '0;
        if (en2) addr2 = addr2 + 1;
        ram_data1 = sr1[2];
        ram_data2 = sr2[7];
        if (d1_rd_en) rd_en_cnt++;
        if (mon && (d1_wr_data !== last_wr)) begin
            check("beat_order", d1_wr_data, exp_next);
            exp_next = exp_next + 1;
            last_wr  = d1_wr_data;
            beats++;
        end
    endtask

    task automatic pulse_done();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
    endtask

    task automatic start_burst(input logic [9:0] len, input logic [127:0] base);
        addr1     = base;
        exp_next  = base;
        rd_en_cnt = 0;
        beats     = 0;
        burst     = len;
        ack       = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) sr1[i] = '0;
        for (int i = 0; i < 8; i++) sr2[i] = '0;

        // reset state
        tick();
        tick();
        check("rst_rd_en", d1_rd_en, 0);
        check("rst_wr_data", d1_wr_data, 0);
        check("rst_busy", d1_busy, 0);
        check("rst_wvld", d1_wvld, 0);
        check("rst_uf", d2_uf, 0);
        rst_n = 1'b1;
        tick();

        // burst of 8 with rdy held high
        rdy = 1'b1;
        mon = 1'b1;
        start_burst(10'd8, 128'h100);
        first = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            ack = 1'b0;
            if (t == 1) check("b8_busy_rise", d1_busy, 1);
            if ((beats > 0) && (first < 0)) first = t;
        end
        check("b8_rd_en_cnt", rd_en_cnt, 8);
        check("b8_beats", beats, 8);
        check("b8_first_beat_tick", first, 6);
        check("b8_busy_before_done", d1_busy, 1);
        pulse_done();
        check("b8_busy_fall", d1_busy, 0);

        // burst of 40 stalled by rdy low: credit caps fetch at DEPTH
        rdy = 1'b0;
        start_burst(10'd40, 128'h1000);
        tick();
        ack = 1'b0;
        for (int t = 0; t < 30; t++) tick();
        check("b40_stall_rd_en", rd_en_cnt, 16);
        check("b40_stall_beats", beats, 0);
        rdy = 1'b1;
        for (int t = 0; t < 80; t++) tick();
        check("b40_rd_en_total", rd_en_cnt, 40);
        check("b40_beats_total", beats, 40);
        check("b40_last_beat", d1_wr_data, 128'h1027);
        pulse_done();

        // op_done mid-burst with fetches in flight
        start_burst(10'd20, 128'h2000);
        tick();
        ack = 1'b0;
        for (int t = 0; t < 30 && beats < 5; t++) tick();
        check("abort_beats_at_done", beats, 5);
        pulse_done();
        for (int t = 0; t < 10; t++) tick();
        check("abort_beats_after", beats, 5);
        check("abort_rd_en_total", rd_en_cnt, 10);
        check("abort_busy", d1_busy, 0);
        start_burst(10'd4, 128'h3000);
        tick();
        ack = 1'b0;
        for (int t = 0; t < 20; t++) tick();
        check("new_rd_en", rd_en_cnt, 4);
        check("new_beats", beats, 4);
        check("new_last", d1_wr_data, 128'h3003);
        pulse_done();

        // read command: ack must not start a fetch
        wr_rdn = 1'b0;
        tick();
        start_burst(10'd8, 128'h5000);
        tick();
        ack = 1'b0;
        wr_rdn = 1'b1;
        for (int t = 0; t < 8; t++) tick();
        check("rd_cmd_rd_en", rd_en_cnt, 0);
        check("rd_cmd_busy", d1_busy, 0);

        // read path retiming: RD_PIPE=1 (dut) and RD_PIPE=4 (dut2)
        for (int c = 0; c < 16; c++) begin
            int k2;
            rd_vld  = (c < 10);
            rd_data = 128'(c);
            tick();
            check("rp1_vld", d1_wvld, (c < 10) ? 1 : 0);
            if (c < 10) check("rp1_data", d1_wdat, 128'(c));
            k2 = c - 3;
            check("rp4_vld", d2_wvld, ((k2 >= 0) && (k2 < 10)) ? 1 : 0);
            if ((k2 >= 0) && (k2 < 10)) check("rp4_data", d2_wdat, 128'(k2));
        end
        rd_vld = 1'b0;

        // reset mid-burst
        mon = 1'b0;
        start_burst(10'd16, 128'h4000);
        tick();
        ack = 1'b0;
        for (int t = 0; t < 20 && rd_en_cnt < 6; t++) tick();
        check("mid_rst_pulses", rd_en_cnt, 6);
        rst_n = 1'b0;
        #1;
        check("async_rd_en", d1_rd_en, 0);
        check("async_wr_data", d1_wr_data, 0);
        check("async_busy", d1_busy, 0);
        check("async_wvld", d1_wvld, 0);
        tick();
        tick();
        rst_n = 1'b1;
        rd_en_cnt = 0;
        for (int t = 0; t < 20; t++) tick();
        check("post_rst_rd_en", rd_en_cnt, 0);
        check("post_rst_busy", d1_busy, 0);
        check("post_rst_wr_data", d1_wr_data, 0);

        // underflow detector on the RAM_LAT=8 instance
        rdy = 1'b0;
        start_burst(10'd8, 128'h6000);
        addr2 = 128'h6000;
        tick();
        ack = 1'b0;
        check("uf_clear_at_start", d2_uf, 0);
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("uf_set", d2_uf, EXP_UF);
        for (int t = 0; t < 10; t++) tick();
        check("uf_sticky", d2_uf, EXP_UF);
        pulse_done();
        check("uf_sticky_idle", d2_uf, EXP_UF);
        start_burst(10'd8, 128'h7000);
        tick();
        ack = 1'b0;
        check("uf_cleared_by_ack", d2_uf, 0);
        pulse_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
